// File: rtl/gfx256_mem_arbiter.sv
// gfx256_mem_arbiter
//
// Round-robin arbiter that shares one 256-bit Wishbone master port between NREQ graphics
// requesters (index 0 is the renderer). Only one bus cycle is in flight at a time. Each
// transfer passes through IDLE -> BUSY -> DONE. The DONE turnaround cycle gives the
// requester time to drop its request, so a stale request is never granted again.
//
// Optional build macro: GFX_ARB_TIMEOUT_EN
//   When this macro is defined, a watchdog aborts a bus cycle after TIMEOUT BUSY cycles
//   without m_ack_i. The abort returns ack_o with err_o = 1.
//   When it is undefined, BUSY waits indefinitely and err_o stays at 0.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_read_i/req_write_i  per-requester level requests (a write wins if both are set)
//   req_addr_i/sel_i/dat_i  packed per-requester address, byte select and write data
//   ack_o, err_o            one-hot completion pulse, timeout flag
//   rdat_o                  read data, held until the next read completes
//   grant_o                 one-hot current owner, 0 when idle
//   m_*                     Wishbone master port
module gfx256_mem_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 256,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_read_i,
  input  logic [NREQ-1:0]        req_write_i,
  input  logic [NREQ*AW-1:0]     req_addr_i,
  input  logic [NREQ*DW/8-1:0]   req_sel_i,
  input  logic [NREQ*DW-1:0]     req_dat_i,
  output logic [NREQ-1:0]        ack_o,
  output logic                   err_o,
  output logic [DW-1:0]          rdat_o,
  output logic [NREQ-1:0]        grant_o,
  output logic                   m_cyc_o,
  output logic                   m_stb_o,
  output logic                   m_we_o,
  output logic [AW-1:0]          m_adr_o,
  output logic [DW/8-1:0]        m_sel_o,
  output logic [DW-1:0]          m_dat_o,
  input  logic [DW-1:0]          m_dat_i,
  input  logic                   m_ack_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT == 0) begin : g_param_check
    $error("gfx256_mem_arbiter: NREQ must be 2..8 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [IW-1:0]   last_q;

`ifdef GFX_ARB_TIMEOUT_EN
  localparam int unsigned TW = 16;
  logic [TW-1:0]   wdog_q;
`endif

  // Search starts one past the previous winner and wraps modulo NREQ.
  logic [NREQ-1:0] active;
  logic [IW-1:0]   win_idx;
  logic            win_found;

  always_comb begin
    int unsigned cand;
    cand      = 0;
    active    = req_read_i | req_write_i;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && active[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= IW'(NREQ - 1);
      ack_o   <= '0;
      err_o   <= 1'b0;
      rdat_o  <= '0;
      grant_o <= '0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_adr_o <= '0;
      m_sel_o <= '0;
      m_dat_o <= '0;
`ifdef GFX_ARB_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      ack_o <= '0;
      err_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            grant_o <= NREQ'(1) << win_idx;
            last_q  <= win_idx;
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_we_o  <= req_write_i[win_idx];
            m_adr_o <= req_addr_i[win_idx*AW +: AW];
            m_sel_o <= req_sel_i[win_idx*SW +: SW];
            m_dat_o <= req_dat_i[win_idx*DW +: DW];
            state_q <= StBusy;
`ifdef GFX_ARB_TIMEOUT_EN
            wdog_q  <= '0;
`endif
          end
        end
        StBusy: begin
          // Requester inputs are not re-sampled here; the master outputs hold their values.
          if (m_ack_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            ack_o   <= grant_o;
            if (!m_we_o) rdat_o <= m_dat_i;
            state_q <= StDone;
          end
`ifdef GFX_ARB_TIMEOUT_EN
          else if (wdog_q == TW'(TIMEOUT - 1)) begin
            // TIMEOUT BUSY cycles have elapsed: abort the cycle and flag the error.
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            ack_o   <= grant_o;
            err_o   <= 1'b1;
            state_q <= StDone;
          end else begin
            wdog_q  <= wdog_q + 1'b1;
          end
`endif
        end
        StDone: begin
          grant_o <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/gfx256_mem_arbiter.md
Name: gfx256_mem_arbiter

Overview:
- Round-robin arbiter sharing the single 256-bit Wishbone master port between NREQ graphics requesters: renderer pixel/z traffic, texture fetch and the blitter read engine.
- Sits between those engines and the wbm.
- Each requester holds a read or write request until it receives a one-cycle ack.
- Exactly one bus cycle is outstanding at a time.

Parameters:
- NREQ, 3, number of requesters (2..8); index 0 is the renderer.
- AW, 32, address width.
- DW, 256, data width; the select width is DW/8.
- TIMEOUT, 255, watchdog cycle limit (used only with GFX_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: synchronous, active-high (one clock; polarity and synchronicity fixed)
- req_read_i  in  NREQ  per-requester read request, level
- req_write_i  in  NREQ  per-requester write request, level
- req_addr_i  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_sel_i  in  NREQ*DW/8  packed byte selects
- req_dat_i  in  NREQ*DW  packed write data
- ack_o  out  NREQ  one-hot, one-cycle completion pulse
- err_o  out  1  high with ack_o when the cycle was aborted by timeout
- rdat_o  out  DW  read data, valid while ack_o is nonzero; held until the next ack
- grant_o  out  NREQ  one-hot current owner; 0 when idle
- m_cyc_o  out  1  Wishbone cycle
- m_stb_o  out  1  Wishbone strobe
- m_we_o  out  1  Wishbone write enable
- m_adr_o  out  AW  Wishbone address
- m_sel_o  out  DW/8  Wishbone byte select
- m_dat_o  out  DW  Wishbone write data
- m_dat_i  in  DW  Wishbone read data
- m_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset: all outputs are 0; state = IDLE; rr pointer last = NREQ-1, so requester 0 has first priority. Reset mid-cycle drops cyc/stb immediately and no ack is issued.
- Request i is active when req_read_i[i] | req_write_i[i]. If both bits are set, the request is a write.
- State IDLE, no active request: stay in IDLE.
- State IDLE, any active request:
  - Pick the winner g = first active index searching last+1, last+2, … modulo NREQ.
  - Register grant_o = onehot(g) and last = g.
  - Register m_cyc_o = m_stb_o = 1, m_we_o, m_adr_o, m_sel_o and m_dat_o from slice g.
  - Go to BUSY. Bus outputs are asserted the cycle after the request is seen, giving one cycle of arbitration latency.
- State BUSY:
  - Master outputs are held constant.
  - Requester inputs are not re-sampled. Requesters must hold their inputs stable until ack, and a change is ignored.
  - When m_ack_i is seen: next edge clears m_cyc_o/m_stb_o/m_we_o, sets ack_o = onehot(g), loads rdat_o = m_dat_i (reads only; writes leave rdat_o unchanged), and goes to DONE.
- State DONE:
  - ack_o returns to 0; grant_o = 0.
  - Next state is IDLE unconditionally. This turnaround cycle lets the requester drop its request before re-arbitration, so a stale request is never re-granted.
  - Minimum spacing is therefore 3 cycles per transfer after m_ack_i.
- A request arriving while BUSY/DONE waits and is considered at the next IDLE.
- Simultaneous requests are resolved purely by the rr pointer. With all requesters active the grant order is 0,1,2,0,…
- A single requester may be granted back-to-back when no other is active.
- m_ack_i while IDLE/DONE is ignored.
- ack_o is never multi-hot; grant_o is never multi-hot.

Optional Feature:
- Macro GFX_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit watchdog counter clears on entry to BUSY and increments each BUSY cycle without m_ack_i.
  - When it reaches TIMEOUT, the cycle is aborted: cyc/stb are dropped, ack_o = onehot(g) and err_o = 1 for that one cycle, rdat_o is unchanged, and the state goes to DONE.
  - An m_ack_i on the same cycle as the timeout takes precedence (normal completion, err_o = 0).
- Not defined: no counter; BUSY waits indefinitely; err_o is tied to 0.

Test Plan:
- Single read: req_read_i=3'b001, addr 0x1000, sel 0xFFFFFFFF; m_ack_i after 4 cycles with m_dat_i=0xA5…A5 → m_cyc_o/m_stb_o high the cycle after the request, m_we_o=0, m_adr_o=0x1000; ack_o=001 and rdat_o=0xA5…A5 one cycle after m_ack_i; IDLE 2 cycles after ack.
- Single write, requester 2: addr 0x2020, sel 0x0000000F, dat 0x12345678 → m_we_o=1 and bus outputs match; ack_o=100; rdat_o unchanged.
- Fairness: all three requesters hold requests, each with 5 transactions, and m_ack_i is given 1 cycle after stb → grant sequence 0,1,2,0,1,2…, each requester receives exactly 5 acks, no multi-hot ack.
- Stale-request check: requester 0 drops its request the cycle after seeing ack, requester 1 pending → the next grant is 1, not 0.
- Reset mid-BUSY: assert rst_i one cycle while m_cyc_o=1 → the next cycle shows all outputs 0, no ack_o pulse, and requester 0 has first priority afterward.
- GFX_ARB_TIMEOUT_EN, TIMEOUT=16, m_ack_i never asserted → ack_o=001 and err_o=1 after 16 BUSY cycles, m_cyc_o=0, and the next request is serviced normally.
